// File: rtl/md_start_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_start_ctrl_if
//  Description : Button / core handshake / status bundle for md_start_ctrl.
//                master = start controller, slave = board and core side.
//  Revision    : 1.0  initial release
// ============================================================================
interface md_start_ctrl_if;
    logic       md_start_push;   // raw button, 1 = released, 0 = pressed
    logic       md_done;         // core completion strobe
    logic       md_match;        // core result matches, qualified by md_done
    logic       md_start;        // one-cycle start pulse to the core
    logic       busy;
    logic       good;
    logic       bad;
    logic       timeout;
    logic [1:0] state_dbg;

    modport master (
        input  md_start_push, md_done, md_match,
        output md_start, busy, good, bad, timeout, state_dbg
    );

    modport slave (
        output md_start_push, md_done, md_match,
        input  md_start, busy, good, bad, timeout, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/md_start_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_start_ctrl
//  Description : Debounces the active-low start button, issues one start
//                pulse per accepted press, supervises the run with a timeout
//                and latches the pass/fail verdict.
//  Revision    : 1.0  initial release
// ============================================================================
module md_start_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    parameter int TIMEOUT_CYCLES  = 20000,
    parameter int TO_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    md_start_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    state_t           state_q;
    logic             md_start_q;
    logic             busy_q;
    logic             good_q;
    logic             bad_q;
    logic             timeout_q;
    logic             press_evt;

    // Two-flop synchronizer for the asynchronous button; idles at released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.md_start_push;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            deb_prev_q <= deb_q;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_MAX) begin
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Only the falling edge of the debounced level is a press; release is silent.
    assign press_evt = deb_prev_q & ~deb_q;

    // Run supervisor; every output is set on the edge that enters its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            md_start_q <= 1'b0;
            busy_q     <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            timeout_q  <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // md_done is deliberately ignored here
                    if (press_evt) begin
                        state_q    <= ST_START;
                        md_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        good_q     <= 1'b0;
                        bad_q      <= 1'b0;
                        timeout_q  <= 1'b0;
                        to_cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    state_q    <= ST_WAIT;
                    md_start_q <= 1'b0;
                    to_cnt_q   <= '0;
                end
                ST_WAIT: begin
                    // A completion in the terminal cycle takes priority over the timeout
                    if (bus.md_done) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        good_q    <= bus.md_match;
                        bad_q     <= ~bus.md_match;
                        timeout_q <= 1'b0;
                    end else if (to_cnt_q == TO_MAX) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        good_q    <= 1'b0;
                        bad_q     <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        to_cnt_q  <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // ST_DONE: verdict stays latched until the next start
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.md_start  = md_start_q;
    assign bus.busy      = busy_q;
    assign bus.good      = good_q;
    assign bus.bad       = bad_q;
    assign bus.timeout   = timeout_q;
    assign bus.state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_md_start_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_start_ctrl
//  Description : Directed self-checking bench for md_start_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_start_ctrl;

    localparam int DEB = 16;
    localparam int TO  = 2000;

    // Observation vector: {md_start, busy, good, bad, timeout, state_dbg[1:0]}
    localparam logic [6:0] O_IDLE      = 7'b0000000;
    localparam logic [6:0] O_START     = 7'b1100001;
    localparam logic [6:0] O_WAIT      = 7'b0100010;
    localparam logic [6:0] O_DONE_GOOD = 7'b0010011;
    localparam logic [6:0] O_DONE_BAD  = 7'b0001011;
    localparam logic [6:0] O_DONE_TO   = 7'b0001111;
    localparam logic [6:0] O_IDLE_GOOD = 7'b0010000;
    localparam logic [6:0] O_IDLE_BAD  = 7'b0001000;
    localparam logic [6:0] O_IDLE_TO   = 7'b0001100;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   start_cnt;
    int   base;

    md_start_ctrl_if bus ();

    md_start_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (8),
        .TIMEOUT_CYCLES  (TO),
        .TO_W            (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [6:0] obs;
    assign obs = {bus.md_start, bus.busy, bus.good, bus.bad, bus.timeout, bus.state_dbg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses away from the active edge
    initial start_cnt = 0;
    always @(negedge clk) if (bus.md_start === 1'b1) start_cnt = start_cnt + 1;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.md_start_push = 1'b1;
        bus.md_done = 1'b0;
        bus.md_match = 1'b0;
        tick(3);
        checks++;
        if (obs !== O_IDLE) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs, O_IDLE);
        end
        rst = 1'b0;
        base = start_cnt;
        tick(1000);
        checks++;
        if (start_cnt - base !== 0) begin
            errors++; $display("FAIL reset_no_start: got %0d pulses expected 0", start_cnt - base);
        end
        checks++;
        if (obs !== O_IDLE) begin
            errors++; $display("FAIL reset_idle: got %b expected %b", obs, O_IDLE);
        end
    endtask

    task automatic test_clean_press();
        base = start_cnt;
        bus.md_start_push = 1'b0;   // first sampled at E0
        tick(18);                   // just after E17
        checks++;
        if (obs !== O_IDLE) begin
            errors++; $display("FAIL press_before_E18: got %b expected %b", obs, O_IDLE);
        end
        tick(1);                    // just after E18
        checks++;
        if (obs !== O_START) begin
            errors++; $display("FAIL press_start_E18: got %b expected %b", obs, O_START);
        end
        tick(1);
        checks++;
        if (obs !== O_WAIT) begin
            errors++; $display("FAIL press_wait: got %b expected %b", obs, O_WAIT);
        end
        tick(8);
        bus.md_done = 1'b1;
        bus.md_match = 1'b1;
        tick(1);
        bus.md_done = 1'b0;
        bus.md_match = 1'b0;
        checks++;
        if (obs !== O_DONE_GOOD) begin
            errors++; $display("FAIL press_done_good: got %b expected %b", obs, O_DONE_GOOD);
        end
        tick(1);
        checks++;
        if (obs !== O_IDLE_GOOD) begin
            errors++; $display("FAIL press_idle_good: got %b expected %b", obs, O_IDLE_GOOD);
        end
        tick(240);
        bus.md_start_push = 1'b1;
        tick(30);
        checks++;
        if (start_cnt - base !== 1) begin
            errors++; $display("FAIL press_one_pulse: got %0d pulses expected 1", start_cnt - base);
        end
    endtask

    task automatic test_bounce();
        base = start_cnt;
        for (int g = 0; g < 3; g++) begin
            bus.md_start_push = 1'b0;
            tick(5);
            bus.md_start_push = 1'b1;
            tick(5);
        end
        tick(30);
        checks++;
        if (start_cnt - base !== 0 || obs !== O_IDLE_GOOD) begin
            errors++; $display("FAIL bounce_rejected: got %0d pulses obs %b expected 0 pulses obs %b",
                               start_cnt - base, obs, O_IDLE_GOOD);
        end
        bus.md_start_push = 1'b0;
        tick(19);
        checks++;
        if (obs !== O_START) begin
            errors++; $display("FAIL bounce_then_press: got %b expected %b", obs, O_START);
        end
        tick(281);
        checks++;
        if (obs !== O_WAIT || start_cnt - base !== 1) begin
            errors++; $display("FAIL bounce_one_pulse: got obs %b pulses %0d expected %b and 1",
                               obs, start_cnt - base, O_WAIT);
        end
        bus.md_done = 1'b1;
        bus.md_match = 1'b1;
        tick(1);
        bus.md_done = 1'b0;
        bus.md_match = 1'b0;
        bus.md_start_push = 1'b1;
        tick(30);
    endtask

    task automatic test_ignored_press();
        base = start_cnt;
        bus.md_start_push = 1'b0;
        tick(19);
        checks++;
        if (obs !== O_START) begin
            errors++; $display("FAIL ign_first_start: got %b expected %b", obs, O_START);
        end
        tick(31);
        bus.md_start_push = 1'b1;
        tick(30);
        bus.md_start_push = 1'b0;   // second debounced press while in WAIT
        tick(40);
        bus.md_start_push = 1'b1;
        tick(30);
        checks++;
        if (obs !== O_WAIT) begin
            errors++; $display("FAIL ign_still_wait: got %b expected %b", obs, O_WAIT);
        end
        bus.md_done = 1'b1;
        bus.md_match = 1'b0;
        tick(1);
        bus.md_done = 1'b0;
        checks++;
        if (obs !== O_DONE_BAD) begin
            errors++; $display("FAIL ign_done_bad: got %b expected %b", obs, O_DONE_BAD);
        end
        tick(50);
        checks++;
        if (obs !== O_IDLE_BAD || start_cnt - base !== 1) begin
            errors++; $display("FAIL ign_single_start: got obs %b pulses %0d expected %b and 1",
                               obs, start_cnt - base, O_IDLE_BAD);
        end
    endtask

    task automatic test_timeout_and_boundary();
        bus.md_start_push = 1'b0;
        tick(19);                   // START cycle
        tick(1);                    // just after Ew
        checks++;
        if (obs !== O_WAIT) begin
            errors++; $display("FAIL to_enter_wait: got %b expected %b", obs, O_WAIT);
        end
        tick(TO - 1);               // just after Ew+1999
        checks++;
        if (obs !== O_WAIT) begin
            errors++; $display("FAIL to_not_early: got %b expected %b", obs, O_WAIT);
        end
        tick(1);                    // just after Ew+2000
        checks++;
        if (obs !== O_DONE_TO) begin
            errors++; $display("FAIL to_done: got %b expected %b", obs, O_DONE_TO);
        end
        tick(1);
        checks++;
        if (obs !== O_IDLE_TO) begin
            errors++; $display("FAIL to_held: got %b expected %b", obs, O_IDLE_TO);
        end
        bus.md_start_push = 1'b1;
        tick(30);
        bus.md_start_push = 1'b0;
        tick(19);
        checks++;
        if (obs !== O_START) begin
            errors++; $display("FAIL to_cleared_at_start: got %b expected %b", obs, O_START);
        end
        // md_done arrives exactly on the terminal timeout edge
        tick(1);
        tick(TO - 1);
        bus.md_done = 1'b1;
        bus.md_match = 1'b1;
        tick(1);
        bus.md_done = 1'b0;
        bus.md_match = 1'b0;
        checks++;
        if (obs !== O_DONE_GOOD) begin
            errors++; $display("FAIL terminal_done_wins: got %b expected %b", obs, O_DONE_GOOD);
        end
        tick(1);
        bus.md_start_push = 1'b1;
        tick(30);
    endtask

    task automatic test_reset_mid_wait();
        base = start_cnt;
        bus.md_start_push = 1'b0;
        tick(19);
        tick(100);
        checks++;
        if (obs !== O_WAIT) begin
            errors++; $display("FAIL rst_pre_wait: got %b expected %b", obs, O_WAIT);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++; $display("FAIL rst_immediate: got %b expected %b", obs, O_IDLE);
        end
        bus.md_start_push = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        bus.md_done = 1'b1;
        bus.md_match = 1'b1;
        tick(1);
        bus.md_done = 1'b0;
        bus.md_match = 1'b0;
        checks++;
        if (obs !== O_IDLE) begin
            errors++; $display("FAIL rst_late_done: got %b expected %b", obs, O_IDLE);
        end
        tick(50);
        checks++;
        if (obs !== O_IDLE || start_cnt - base !== 1) begin
            errors++; $display("FAIL rst_quiet: got obs %b pulses %0d expected %b and 1",
                               obs, start_cnt - base, O_IDLE);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        base   = 0;
        rst    = 1'b1;
        bus.md_start_push = 1'b1;
        bus.md_done  = 1'b0;
        bus.md_match = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_ignored_press();
        test_timeout_and_boundary();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_start_ctrl.md
# md_start_ctrl

Front-end controller that turns the raw, active-low, bouncing start push-button of the RSA32 test harness into a single clean start pulse for the modular-exponentiation core. It then supervises the run and reports the verdict. It waits for the core's done/match handshake, guards the run with a timeout, and latches the pass/fail result on status outputs. It sits between the board button and the core, on the driving side of the core's start input, and is the source of the good/bad indicators.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a new button level (≥2).
- CNT_W, 8: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- TIMEOUT_CYCLES, 20000: maximum cycles spent in WAIT before declaring failure (≥2).
- TO_W, 16: timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- md_start_push  in  1  raw button: 1 = released, 0 = pressed; asynchronous, may bounce.
- md_done  in  1  core completion strobe, one cycle.
- md_match  in  1  core result equals expected value; valid only when md_done=1.
- md_start  out  1  one-cycle start pulse to the core.
- busy  out  1  high in START and WAIT.
- good  out  1  last run completed with match.
- bad  out  1  last run mismatched or timed out.
- timeout  out  1  last run ended by timeout.
- state_dbg  out  2  current FSM state encoding.

## Operation
- Synchronizer: two flops, both reset to 1.
- Debouncer:
  - Holds the debounced level `deb`, reset to 1, and a counter `cnt`, reset to 0.
  - If the synchronizer output equals `deb`, `cnt` clears to 0.
  - Otherwise, if `cnt` = DEBOUNCE_CYCLES-1, `deb` takes the new level and `cnt` clears.
  - Otherwise `cnt` increments.
- Press event: `deb` transitions from 1 to 0. A release (0 to 1) produces no event. A button held through reset counts as a press once debounced.
- FSM states and encoding: IDLE=0, START=1, WAIT=2, DONE=3.
  - IDLE: a press event moves to START. md_done is ignored.
  - START: md_start=1. good, bad, timeout and the timeout counter are cleared. Unconditionally moves to WAIT.
  - WAIT: the timeout counter increments each cycle.
    - md_done=1: good=md_match, bad=~md_match, timeout=0; go to DONE.
    - Otherwise, counter = TIMEOUT_CYCLES-1: bad=1, timeout=1, good=0; go to DONE.
    - md_done in the terminal cycle wins over the timeout.
  - DONE: unconditionally moves to IDLE. Results remain held until the next START.
- Press events in START, WAIT or DONE are discarded, not queued. A new run needs a full release and re-press after IDLE is reached.
- good and bad are never both 1.

## Timing
- Reset values: md_start, busy, good, bad, timeout = 0; state_dbg = 0 (IDLE). Synchronizer flops and `deb` = 1; counters = 0.
- Reset asserted mid-run aborts immediately to IDLE with all outputs 0. A later md_done is ignored.
- Press latency: let E0 be the first edge that samples md_start_push=0. If the level stays low, `deb` falls at E(DEBOUNCE_CYCLES+1) and the FSM enters START at E(DEBOUNCE_CYCLES+2).
- md_start is registered (state==START) and is high for exactly the one cycle following edge E(DEBOUNCE_CYCLES+2).
- Any low or high excursion shorter than DEBOUNCE_CYCLES synchronized samples is rejected.
- Completion latency: md_done sampled at edge Ed means good/bad are valid after Ed. DONE occupies the cycle after Ed, and IDLE is reached at Ed+1.
- Timeout: WAIT entered at edge Ew means that, absent md_done, DONE is entered at Ew+TIMEOUT_CYCLES.
- busy is high from the START cycle through the last WAIT cycle.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=16, TIMEOUT_CYCLES=2000.
- Reset: hold rst for 3 cycles, button released -> all outputs 0, state_dbg=0. Release rst -> no md_start for 1000 cycles.
- Clean press: button low for 270 cycles, md_done=1 with md_match=1 ten cycles after md_start -> exactly one md_start pulse, in the cycle after E18. Then good=1, bad=0, busy=0, state returns to 0.
- Bounce rejection: three 5-cycle low glitches separated by 5-cycle highs -> no md_start. A following 300-cycle low press -> one pulse.
- Ignored press: a second debounced press during WAIT, then md_done with md_match=0 -> only one md_start in total; bad=1, good=0.
- Timeout: press, md_done never asserted -> DONE at Ew+2000 with bad=1, timeout=1, good=0. A new press clears all three at START.
- Boundary/reset: md_done=1 with md_match=1 exactly in the terminal timeout cycle -> good=1, timeout=0. Separately, rst pulsed mid-WAIT -> outputs 0 at once, and a late md_done -> no change.
